branch_predict_unit: RTL and testbench

//  Execute-stage branch resolution unit with a built-in 2-bit bimodal predictor.

---
 rtl/branch_predict_unit_pkg.sv | 27 ++
 rtl/branch_predict_unit_bht.sv | 34 +++
 rtl/branch_predict_unit.sv | 108 ++++++++++
 tb/tb_branch_predict_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch resolution unit: func3 codes, 2-bit counter encoding and saturating step helpers.
// Latency: none (types and pure functions only); backpressure: not applicable.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_bht.sv
// Bimodal table of 2-bit saturating counters: async read for fetch, sync train-by-outcome write for execute.
// Latency: read 0 cycles, write visible the cycle after; backpressure: none, one write per cycle.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int   BHT_ENTRIES = 16,
    parameter ctr_t CTR_INIT    = WNT,
    localparam int  IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    ctr_t ctr_q [BHT_ENTRIES];

    // Fetch sees the pre-update value when it reads the entry being trained.
    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_taken ? sat_inc(ctr_q[wr_idx]) : sat_dec(ctr_q[wr_idx]);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a bimodal predictor, mispredict flagging and saturating perf counters.
// Latency: results registered 1 cycle after issue, prediction combinational; backpressure: none, 1 instr/cycle.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int   XLEN        = 32,
    parameter int   BHT_ENTRIES = 16,
    parameter int   INDEX_LSB   = 2,
    parameter ctr_t CTR_INIT    = WNT,
    parameter int   CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_kill,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_binst,
    input  logic             ex_jal,
    input  logic [2:0]       ex_func3,
    input  logic [XLEN-1:0]  ex_rs1data,
    input  logic [XLEN-1:0]  ex_rs2data,
    input  logic             ex_pred_taken,
    output logic             res_valid,
    output logic             rs1pc,
    output logic             pcjump,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic taken;
    logic go;
    logic train;
    logic rs1pc_nxt;
    logic pcjump_nxt;
    logic mp_nxt;
    ctr_t pred_ctr;
    logic unused_bits;

    always_comb begin
        taken = 1'b0;
        case (ex_func3)
            F3_BEQ:  taken = (ex_rs1data == ex_rs2data);
            F3_BNE:  taken = (ex_rs1data != ex_rs2data);
            F3_BLT:  taken = ($signed(ex_rs1data) <  $signed(ex_rs2data));
            F3_BGE:  taken = ($signed(ex_rs1data) >= $signed(ex_rs2data));
            F3_BLTU: taken = (ex_rs1data <  ex_rs2data);
            F3_BGEU: taken = (ex_rs1data >= ex_rs2data);
            default: taken = 1'b0;
        endcase
    end

    // A jump that also claims to be a branch is resolved purely as a jump.
    assign go         = ex_valid & ~ex_kill;
    assign train      = go & ex_binst & ~ex_jal;
    assign rs1pc_nxt  = train & taken;
    assign pcjump_nxt = go & (ex_jal | rs1pc_nxt);
    assign mp_nxt     = train & (taken != ex_pred_taken);

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_INIT    (CTR_INIT)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pred_pc[INDEX_LSB +: IDX_W]),
        .rd_ctr   (pred_ctr),
        .wr_en    (train),
        .wr_idx   (ex_pc[INDEX_LSB +: IDX_W]),
        .wr_taken (taken)
    );

    assign pred_taken  = pred_ctr[1];
    assign unused_bits = ^{pred_pc, ex_pc, pred_ctr[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            rs1pc      <= 1'b0;
            pcjump     <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            res_valid  <= go;
            rs1pc      <= rs1pc_nxt;
            pcjump     <= pcjump_nxt;
            mispredict <= mp_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (train && br_count != '1) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mp_nxt && mp_count != '1) begin
                mp_count <= mp_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a reference predictor model and a result scoreboard.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken, pred_taken_s;
    logic        ex_valid, ex_kill, ex_binst, ex_jal, ex_pred_taken;
    logic [31:0] ex_pc, ex_rs1data, ex_rs2data;
    logic [2:0]  ex_func3;
    logic        res_valid, rs1pc, pcjump, mispredict;
    logic        res_valid_s, rs1pc_s, pcjump_s, mispredict_s;
    logic [15:0] br_count, mp_count;
    logic [1:0]  br_count_s, mp_count_s;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_kill(ex_kill), .ex_pc(ex_pc), .ex_binst(ex_binst),
        .ex_jal(ex_jal), .ex_func3(ex_func3), .ex_rs1data(ex_rs1data),
        .ex_rs2data(ex_rs2data), .ex_pred_taken(ex_pred_taken), .res_valid(res_valid),
        .rs1pc(rs1pc), .pcjump(pcjump), .mispredict(mispredict),
        .br_count(br_count), .mp_count(mp_count)
    );

    // Narrow counters so saturation is reachable in a short run.
    branch_predict_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken_s),
        .ex_valid(ex_valid), .ex_kill(ex_kill), .ex_pc(ex_pc), .ex_binst(ex_binst),
        .ex_jal(ex_jal), .ex_func3(ex_func3), .ex_rs1data(ex_rs1data),
        .ex_rs2data(ex_rs2data), .ex_pred_taken(ex_pred_taken), .res_valid(res_valid_s),
        .rs1pc(rs1pc_s), .pcjump(pcjump_s), .mispredict(mispredict_s),
        .br_count(br_count_s), .mp_count(mp_count_s)
    );

    typedef struct {
        logic rv;
        logic tk;
        logic pj;
        logic mp;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  m_tbl [16];
    int          m_br, m_mp, m_br_s, m_mp_s;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return !($signed(a) < $signed(b));
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
        m_br = 0; m_mp = 0; m_br_s = 0; m_mp_s = 0;
    endtask

    // Drive one execute slot, check the same-cycle prediction, then score the registered result.
    task automatic step(input string tag, input logic v, input logic k, input logic [31:0] pc,
                        input logic bi, input logic j, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic pt);
        exp_t e, got;
        logic tk;
        ex_valid = v; ex_kill = k; ex_pc = pc; ex_binst = bi; ex_jal = j;
        ex_func3 = f3; ex_rs1data = a; ex_rs2data = b; ex_pred_taken = pt;
        #1;
        chk({tag, "/pred_pre"}, {31'd0, pred_taken}, {31'd0, m_tbl[idx(pred_pc)][1]});
        tk = cond(f3, a, b);
        if (rst) begin
            e = '{1'b0, 1'b0, 1'b0, 1'b0};
            model_reset();
        end else begin
            e.rv = v & ~k;
            e.tk = e.rv & bi & ~j & tk;
            e.pj = e.rv & (j | e.tk);
            e.mp = e.rv & bi & ~j & (tk != pt);
            if (e.rv & bi & ~j) begin
                if (tk) m_tbl[idx(pc)] = (m_tbl[idx(pc)] == 2'b11) ? 2'b11 : m_tbl[idx(pc)] + 2'b01;
                else    m_tbl[idx(pc)] = (m_tbl[idx(pc)] == 2'b00) ? 2'b00 : m_tbl[idx(pc)] - 2'b01;
                m_br++;
                if (m_br_s < 3) m_br_s++;
            end
            if (e.mp) begin
                m_mp++;
                if (m_mp_s < 3) m_mp_s++;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_kill = 1'b0; ex_binst = 1'b0; ex_jal = 1'b0;
        got = sb.pop_front();
        chk({tag, "/res"}, {28'd0, res_valid, rs1pc, pcjump, mispredict},
            {28'd0, got.rv, got.tk, got.pj, got.mp});
        chk({tag, "/cnt"}, {br_count, mp_count}, {m_br[15:0], m_mp[15:0]});
        chk({tag, "/cnt_sat"}, {28'd0, br_count_s, mp_count_s}, {28'd0, m_br_s[1:0], m_mp_s[1:0]});
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        chk(tag, {31'd0, pred_taken}, {31'd0, exp});
        chk({tag, "/model"}, {31'd0, pred_taken}, {31'd0, m_tbl[idx(pc)][1]});
    endtask

    initial begin
        rst = 1'b1;
        pred_pc = 32'h40;
        ex_valid = 1'b0; ex_kill = 1'b0; ex_pc = '0; ex_binst = 1'b0; ex_jal = 1'b0;
        ex_func3 = '0; ex_rs1data = '0; ex_rs2data = '0; ex_pred_taken = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step("rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 1'b0);
        rst = 1'b0;

        step("idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 0, 0, 1'b0);
        check_pred("pred_reset", 32'h40, 1'b0);

        step("beq_eq", 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 3'b000, 5, 5, 1'b0);
        check_pred("pred_after_beq", 32'h40, 1'b1);

        step("blt_neg", 1'b1, 1'b0, 32'h48, 1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 1, 1'b1);
        step("bltu_big", 1'b1, 1'b0, 32'h48, 1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 1, 1'b0);
        step("f3_010", 1'b1, 1'b0, 32'h48, 1'b1, 1'b0, 3'b010, 3, 3, 1'b1);
        step("f3_011", 1'b1, 1'b0, 32'h48, 1'b1, 1'b0, 3'b011, 3, 4, 1'b0);
        step("bne", 1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 3'b001, 3, 4, 1'b0);
        step("bge_eq", 1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h8000_0000, 1'b1);
        step("bge_neg", 1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 3'b101, 32'h8000_0000, 0, 1'b1);
        step("bgeu", 1'b1, 1'b0, 32'h50, 1'b1, 1'b0, 3'b111, 32'h8000_0000, 0, 1'b0);
        step("beq_ne", 1'b1, 1'b0, 32'h54, 1'b1, 1'b0, 3'b000, 1, 2, 1'b1);

        pred_pc = 32'h44;
        for (int i = 0; i < 5; i++) begin
            step("tk44", 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 3'b000, 7, 7, 1'b1);
        end
        check_pred("pred_sat", 32'h44, 1'b1);
        step("nt44", 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 3'b001, 7, 7, 1'b1);
        check_pred("pred_wt", 32'h44, 1'b1);

        step("jal_binst", 1'b1, 1'b0, 32'h44, 1'b1, 1'b1, 3'b001, 7, 7, 1'b1);
        check_pred("pred_jal", 32'h44, 1'b1);
        step("jal", 1'b1, 1'b0, 32'h60, 1'b0, 1'b1, 3'b000, 0, 0, 1'b0);
        step("kill", 1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 3'b001, 7, 7, 1'b1);
        step("nt44b", 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 3'b001, 7, 7, 1'b1);
        check_pred("pred_wnt", 32'h44, 1'b0);

        pred_pc = 32'h4C;
        step("collide", 1'b1, 1'b0, 32'h4C, 1'b1, 1'b0, 3'b000, 1, 1, 1'b0);
        check_pred("pred_collide_new", 32'h4C, 1'b1);

        rst = 1'b1;
        step("rst_pend", 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 3'b000, 1, 1, 1'b0);
        rst = 1'b0;
        check_pred("pred_rst_40", 32'h40, 1'b0);
        check_pred("pred_rst_4c", 32'h4C, 1'b0);

        for (int i = 0; i < 5; i++) begin
            step("sat_cnt", 1'b1, 1'b0, 32'h58, 1'b1, 1'b0, 3'b001, i, 99, 1'b0);
        end
        step("sat_hold", 1'b1, 1'b0, 32'h58, 1'b1, 1'b0, 3'b000, 1, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
